lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen.sv | 101 ++++++++++
 tb/tb_lfsr_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised pseudo-random sequence generator.
//
// Produces a Fibonacci or Galois LFSR sequence with step enable, runtime seed
// load, recovery from the all-zero state and measurement of the sequence period.
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   en       advance one step this cycle
//   load     load seed_in this cycle (takes priority over en)
//   seed_in  runtime seed; zero selects SEED
//   lfsr     current state (registered)
//   bit_out  lfsr[0], serial PRBS bit
//   wrap     one-cycle pulse: state has returned to the reference value
//   lockup   one-cycle pulse: all-zero state (or zero seed) replaced by SEED
//   period   step count of the last completed cycle; 0 until the first wrap
module lfsr_gen #(
    parameter int          WIDTH = 5,
    parameter logic [31:0] TAPS  = 32'h0000_0005,
    parameter logic [31:0] SEED  = 32'h0000_0001,
    parameter bit          MODE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] period
);

    localparam logic [WIDTH-1:0] TAPS_W   = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] ref_val;
    logic [WIDTH-1:0] step_cnt;

    logic             fb;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] cnt_inc;
    logic             seed_zero;
    logic [WIDTH-1:0] seed_eff;

    always_comb begin
        fb        = ^(lfsr & TAPS_W);
        step_val  = {fb, lfsr[WIDTH-1:1]};
        if (MODE) begin
            step_val = (lfsr >> 1) ^ (lfsr[0] ? TAPS_W : '0);
        end
        // Saturate so a very long (or stuck) sequence can never alias to a short period.
        cnt_inc   = (step_cnt == ALL_ONES) ? ALL_ONES : step_cnt + 1'b1;
        seed_zero = (seed_in == '0);
        seed_eff  = seed_zero ? SEED_W : seed_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= SEED_W;
            ref_val  <= SEED_W;
            step_cnt <= '0;
            period   <= '0;
            wrap     <= 1'b0;
            lockup   <= 1'b0;
        end else if (load) begin
            lfsr     <= seed_eff;
            ref_val  <= seed_eff;
            step_cnt <= '0;
            period   <= '0;
            wrap     <= 1'b0;
            lockup   <= seed_zero;
        end else if (en) begin
            if (lfsr == '0) begin
                // Recovery step: leaves the period measurement untouched.
                lfsr   <= SEED_W;
                wrap   <= 1'b0;
                lockup <= 1'b1;
            end else begin
                lfsr   <= step_val;
                lockup <= 1'b0;
                if (step_val == ref_val) begin
                    wrap     <= 1'b1;
                    period   <= cnt_inc;
                    step_cnt <= '0;
                end else begin
                    wrap     <= 1'b0;
                    step_cnt <= cnt_inc;
                end
            end
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end
    end

    assign bit_out = lfsr[0];

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, load;
    logic [31:0] sin;

    logic [4:0]  l0, l1, l2, p0, p1, p2;
    logic [15:0] l3, p3;
    logic        b0, b1, b2, b3, w0, w1, w2, w3, k0, k1, k2, k3;

    // 0: Fibonacci default, 1: Galois 5-bit, 2: Fibonacci non-maximal (hits zero), 3: Galois 16-bit
    lfsr_gen #(.WIDTH(5), .TAPS(32'h05), .SEED(32'h1), .MODE(1'b0)) u0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(sin[4:0]),
        .lfsr(l0), .bit_out(b0), .wrap(w0), .lockup(k0), .period(p0));
    lfsr_gen #(.WIDTH(5), .TAPS(32'h05), .SEED(32'h1), .MODE(1'b1)) u1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(sin[4:0]),
        .lfsr(l1), .bit_out(b1), .wrap(w1), .lockup(k1), .period(p1));
    lfsr_gen #(.WIDTH(5), .TAPS(32'h02), .SEED(32'h1), .MODE(1'b0)) u2 (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(sin[4:0]),
        .lfsr(l2), .bit_out(b2), .wrap(w2), .lockup(k2), .period(p2));
    lfsr_gen #(.WIDTH(16), .TAPS(32'hB400), .SEED(32'h1), .MODE(1'b1)) u3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(sin[15:0]),
        .lfsr(l3), .bit_out(b3), .wrap(w3), .lockup(k3), .period(p3));

    logic [31:0] d_lfsr [4];
    logic [31:0] d_per  [4];
    logic        d_bit  [4];
    logic        d_wrap [4];
    logic        d_lock [4];

    assign d_lfsr[0] = 32'(l0);  assign d_per[0] = 32'(p0);
    assign d_lfsr[1] = 32'(l1);  assign d_per[1] = 32'(p1);
    assign d_lfsr[2] = 32'(l2);  assign d_per[2] = 32'(p2);
    assign d_lfsr[3] = 32'(l3);  assign d_per[3] = 32'(p3);
    assign d_bit[0] = b0;  assign d_wrap[0] = w0;  assign d_lock[0] = k0;
    assign d_bit[1] = b1;  assign d_wrap[1] = w1;  assign d_lock[1] = k1;
    assign d_bit[2] = b2;  assign d_wrap[2] = w2;  assign d_lock[2] = k2;
    assign d_bit[3] = b3;  assign d_wrap[3] = w3;  assign d_lock[3] = k3;

    typedef struct {
        int          id;
        logic [31:0] lfsr;
        logic        bo;
        logic        wr;
        logic        lk;
        logic [31:0] per;
    } rec_t;

    rec_t q[$];
    int checks = 0;
    int passed = 0;

    // Reference model: one entry per instance
    int unsigned m_w    [4] = '{5, 5, 5, 16};
    logic [31:0] m_taps [4] = '{32'h05, 32'h05, 32'h02, 32'hB400};
    logic [31:0] m_seed [4] = '{32'h1, 32'h1, 32'h1, 32'h1};
    bit          m_gal  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] m_s    [4];
    logic [31:0] m_ref  [4];
    longint      m_cnt  [4];
    logic [31:0] m_per  [4];
    logic        m_wrap [4];
    logic        m_lock [4];

    logic [31:0] fib_tbl [7] = '{32'h01, 32'h10, 32'h08, 32'h04, 32'h12, 32'h09, 32'h14};
    logic [31:0] gal_tbl [5] = '{32'h01, 32'h05, 32'h07, 32'h06, 32'h03};

    function automatic logic [31:0] mask_of(int i);
        return (m_w[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << m_w[i]) - 32'd1);
    endfunction

    function automatic logic [31:0] model_next(int i, logic [31:0] s);
        logic [31:0] r;
        int unsigned parity;
        if (m_gal[i]) begin
            r = (s >> 1) ^ ((s % 2 == 1) ? m_taps[i] : 32'd0);
        end else begin
            parity = $countones(s & m_taps[i]) % 2;
            r = (s >> 1) + (32'(parity) << (m_w[i] - 1));
        end
        return r & mask_of(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle (called at a negedge), advance the model, push expectations,
    // then return at the following negedge with the DUT outputs settled.
    task automatic tick(input logic r, input logic e, input logic l, input logic [31:0] s);
        logic [31:0] mk, sv, nx;
        longint      sat;
        rec_t        rec;
        reset = r; en = e; load = l; sin = s;
        for (int i = 0; i < 4; i++) begin
            mk  = mask_of(i);
            sv  = s & mk;
            if (r) begin
                m_s[i] = m_seed[i]; m_ref[i] = m_seed[i];
                m_cnt[i] = 0; m_per[i] = 0; m_wrap[i] = 0; m_lock[i] = 0;
            end else if (l) begin
                m_s[i]    = (sv == 0) ? m_seed[i] : sv;
                m_ref[i]  = m_s[i];
                m_cnt[i]  = 0; m_per[i] = 0; m_wrap[i] = 0;
                m_lock[i] = (sv == 0);
            end else if (e) begin
                if (m_s[i] == 0) begin
                    m_s[i] = m_seed[i]; m_wrap[i] = 0; m_lock[i] = 1;
                end else begin
                    nx  = model_next(i, m_s[i]);
                    sat = (m_cnt[i] + 1 > longint'(mk)) ? longint'(mk) : m_cnt[i] + 1;
                    m_lock[i] = 0;
                    if (nx == m_ref[i]) begin
                        m_wrap[i] = 1; m_per[i] = 32'(sat); m_cnt[i] = 0;
                    end else begin
                        m_wrap[i] = 0; m_cnt[i] = sat;
                    end
                    m_s[i] = nx;
                end
            end else begin
                m_wrap[i] = 0; m_lock[i] = 0;
            end
            rec.id = i; rec.lfsr = m_s[i]; rec.bo = m_s[i][0];
            rec.wr = m_wrap[i]; rec.lk = m_lock[i]; rec.per = m_per[i];
            q.push_back(rec);
        end
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new output every edge; compare against the queue.
    always @(posedge clk) begin
        rec_t r;
        #1;
        while (q.size() > 0) begin
            r = q.pop_front();
            checks++;
            if (d_lfsr[r.id] === r.lfsr && d_bit[r.id] === r.bo && d_wrap[r.id] === r.wr &&
                d_lock[r.id] === r.lk && d_per[r.id] === r.per) begin
                passed++;
            end else begin
                $display("FAIL sb[%0d] t=%0t: got lfsr=%0h bit=%0b wrap=%0b lock=%0b per=%0h, expected lfsr=%0h bit=%0b wrap=%0b lock=%0b per=%0h",
                         r.id, $time, d_lfsr[r.id], d_bit[r.id], d_wrap[r.id], d_lock[r.id], d_per[r.id],
                         r.lfsr, r.bo, r.wr, r.lk, r.per);
            end
        end
    end

    initial begin
        logic [31:0] rs;
        reset = 1'b1; en = 1'b0; load = 1'b0; sin = '0;
        @(negedge clk);

        // Reset state and default Fibonacci / Galois sequences
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_lfsr", d_lfsr[0], 32'h1);
        chk("rst_period", d_per[0], 32'h0);
        chk("rst_wrap", 32'(d_wrap[0]), 32'h0);
        chk("rst_lockup", 32'(d_lock[0]), 32'h0);
        chk("gal_rst_lfsr", d_lfsr[1], gal_tbl[0]);
        for (int i = 1; i <= 30; i++) begin
            tick(0, 1, 0, 0);
            if (i < 7) begin
                chk("fib_seq", d_lfsr[0], fib_tbl[i]);
                chk("fib_bit", 32'(d_bit[0]), fib_tbl[i] & 32'h1);
            end
            if (i < 5) chk("gal_seq", d_lfsr[1], gal_tbl[i]);
            chk("fib_no_early_wrap", 32'(d_wrap[0]), 32'h0);
        end
        tick(0, 1, 0, 0);
        chk("fib_wrap31", 32'(d_wrap[0]), 32'h1);
        chk("fib_wrap_lfsr", d_lfsr[0], 32'h1);
        chk("fib_period31", d_per[0], 32'd31);
        tick(0, 1, 0, 0);
        chk("wrap_pulse_end", 32'(d_wrap[0]), 32'h0);
        chk("period_held", d_per[0], 32'd31);

        // Runtime load (with en also high) and wrap back to the loaded value
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        tick(0, 1, 1, 32'h0A);
        chk("load_lfsr", d_lfsr[0], 32'h0A);
        chk("load_period", d_per[0], 32'h0);
        for (int i = 1; i <= 30; i++) tick(0, 1, 0, 0);
        chk("load_no_wrap30", 32'(d_wrap[0]), 32'h0);
        tick(0, 1, 0, 0);
        chk("load_wrap31", 32'(d_wrap[0]), 32'h1);
        chk("load_wrap_lfsr", d_lfsr[0], 32'h0A);
        chk("load_period31", d_per[0], 32'd31);

        // Zero seed substitutes SEED and pulses lockup
        tick(0, 1, 1, 32'h0);
        chk("zload_lfsr", d_lfsr[0], 32'h1);
        chk("zload_lockup", 32'(d_lock[0]), 32'h1);
        tick(0, 0, 0, 0);
        chk("zload_lockup_end", 32'(d_lock[0]), 32'h0);
        chk("zload_hold", d_lfsr[0], 32'h1);

        // Non-maximal taps reach zero; next step recovers to SEED
        tick(0, 1, 0, 0);
        chk("nm_zero", d_lfsr[2], 32'h0);
        tick(0, 1, 0, 0);
        chk("nm_recover", d_lfsr[2], 32'h1);
        chk("nm_lockup", 32'(d_lock[2]), 32'h1);
        chk("nm_period", d_per[2], 32'h0);
        tick(0, 1, 0, 0);
        chk("nm_lockup_end", 32'(d_lock[2]), 32'h0);

        // Enable gating 1,0,0,1
        tick(0, 1, 0, 0); chk("gate_step", d_lfsr[0], m_s[0]);
        tick(0, 0, 0, 0); chk("gate_hold1", d_lfsr[0], m_s[0]);
        tick(0, 0, 0, 0); chk("gate_hold2", d_lfsr[0], m_s[0]);
        tick(0, 1, 0, 0); chk("gate_step2", d_lfsr[0], m_s[0]);

        // Randomised traffic, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            tick(($urandom_range(49) == 0), ($urandom_range(9) < 7), ($urandom_range(19) == 0), rs);
        end

        // Reset mid-run and identical restart
        tick(1, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("mrst_lfsr", d_lfsr[0], 32'h1);
        chk("mrst_period", d_per[0], 32'h0);
        chk("mrst_wrap", 32'(d_wrap[0]), 32'h0);
        chk("mrst_lockup", 32'(d_lock[0]), 32'h0);
        for (int i = 1; i < 7; i++) begin
            tick(0, 1, 0, 0);
            chk("mrst_seq", d_lfsr[0], fib_tbl[i]);
        end

        // 16-bit Galois maximal period
        tick(1, 0, 0, 0);
        for (int i = 1; i < 65535; i++) tick(0, 1, 0, 0);
        chk("g16_no_early_wrap", 32'(d_wrap[3]), 32'h0);
        tick(0, 1, 0, 0);
        chk("g16_wrap", 32'(d_wrap[3]), 32'h1);
        chk("g16_lfsr", d_lfsr[3], 32'h1);
        chk("g16_period", d_per[3], 32'd65535);

        tick(0, 0, 0, 0);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
